// File: rtl/gf_pkg.sv
// Shared GF(2^m) datapath definitions: field degree, divider state encoding
// and the worst-case iteration bound of the binary extended Euclid loop.
package gf_pkg;

    localparam int GF_WIDTH   = 32;
    // 2*m halvings + 2*m xor steps + a few terminal cycles
    localparam int GF_MAX_CYC = 4 * GF_WIDTH + 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gf_state_e;

endpackage

// File: rtl/gf_halve.sv
// Multiply a field element by x^-1 modulo P = x^WIDTH + poly.
// When z is odd, adding P makes it even (poly[0] is 1) and the implicit
// x^WIDTH term lands in the top bit after the shift.
module gf_halve
    import gf_pkg::*;
#(
    parameter int WIDTH = GF_WIDTH
) (
    input  logic [WIDTH-1:0] z,
    input  logic [WIDTH-1:0] poly,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] t_s;

    // Conditionally add P's low part so the value becomes divisible by x
    always_comb begin
        if (z[0]) begin
            t_s = z ^ poly;
        end else begin
            t_s = z;
        end
    end

    assign r = WIDTH'({z[0], t_s} >> 1);

endmodule

// File: rtl/gf_div.sv
// Sequential GF(2^WIDTH) divider q = a / b mod (x^WIDTH + poly), using the
// binary extended Euclid algorithm, one step per cycle. Invariants kept:
// U*a == X*b and V*a == Y*b; when U or V reaches 1 the matching X or Y is a/b.
module gf_div
    import gf_pkg::*;
#(
    parameter int WIDTH = GF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] poly,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] q,
    output logic             div_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    gf_state_e        state_r, state_n;
    logic [WIDTH:0]   u_r, v_r, u_n, v_n;
    logic [WIDTH-1:0] x_r, y_r, pc_r, x_n, y_n;
    logic [WIDTH-1:0] x_half_s, y_half_s;
    logic             finish_s;

    gf_halve #(.WIDTH(WIDTH)) u_halve_x (.z(x_r), .poly(pc_r), .r(x_half_s));
    gf_halve #(.WIDTH(WIDTH)) u_halve_y (.z(y_r), .poly(pc_r), .r(y_half_s));

    assign finish_s = (u_r == ONE) || (v_r == ONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic: zero divisor skips the loop, results wait for the consumer
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_n = (b == '0) ? DONE : RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (finish_s) begin
                    state_n = DONE;
                end else begin
                    state_n = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_r)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    // One Euclid step: halve an even operand first, otherwise subtract (xor)
    // the smaller from the larger and mirror the update on the cofactor
    always_comb begin
        u_n = u_r;
        v_n = v_r;
        x_n = x_r;
        y_n = y_r;
        if (finish_s) begin
            u_n = u_r;
        end else if (!u_r[0]) begin
            u_n = u_r >> 1;
            x_n = x_half_s;
        end else if (!v_r[0]) begin
            v_n = v_r >> 1;
            y_n = y_half_s;
        end else if (u_r > v_r) begin
            u_n = u_r ^ v_r;
            x_n = x_r ^ y_r;
        end else begin
            v_n = v_r ^ u_r;
            y_n = y_r ^ x_r;
        end
    end

    // Operand capture, iteration state and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            u_r      <= '0;
            v_r      <= '0;
            x_r      <= '0;
            y_r      <= '0;
            pc_r     <= '0;
            q        <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        u_r      <= {1'b0, b};
                        v_r      <= {1'b1, poly};
                        x_r      <= a;
                        y_r      <= '0;
                        pc_r     <= poly;
                        q        <= '0;
                        div_zero <= (b == '0);
                    end
                end
                RUN: begin
                    if (u_r == ONE) begin
                        q <= x_r;
                    end else if (v_r == ONE) begin
                        q <= y_r;
                    end else begin
                        u_r <= u_n;
                        v_r <= v_n;
                        x_r <= x_n;
                        y_r <= y_n;
                    end
                end
                DONE: begin
                    q <= q;
                end
                default: begin
                    q <= q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf_div.sv
// Randomised self-checking bench for gf_div. Expected quotients come from a
// field model: q = a * b^(2^32-2), with a plain shift-and-reduce multiplier.
module tb_gf_div;
    import gf_pkg::*;

    localparam logic [31:0] P1 = 32'h0040_0007;
    localparam logic [31:0] P2 = 32'h0000_008D;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] poly, a, b, q;
    logic        in_valid, in_ready, div_zero, out_valid, out_ready, busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_q;
    logic        m_dz;
    bit          m_armed = 1'b0;
    bit          live = 1'b0;

    always #5 clk = ~clk;

    gf_div dut (
        .clk(clk), .rst(rst), .poly(poly), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready), .q(q), .div_zero(div_zero),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    function automatic logic [31:0] gf_mul(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] p);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 31; i >= 0; i--) begin
            r = r[31] ? ((r << 1) ^ p) : (r << 1);
            if (y[i]) r = r ^ x;
        end
        return r;
    endfunction

    // a / b as a * b^(2^32 - 2), valid because the multiplicative group has 2^32-1 elements
    function automatic logic [31:0] gf_div_model(input logic [31:0] x, input logic [31:0] y,
                                                 input logic [31:0] p);
        logic [31:0] r, base, e;
        r = 32'h1;
        base = y;
        e = 32'hFFFF_FFFE;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = gf_mul(r, base, p);
            base = gf_mul(base, base, p);
        end
        return gf_mul(x, r, p);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Compare process: every cycle, a held result must match the model and
    // no result may appear when none is outstanding
    always @(negedge clk) begin
        if (live) begin
            if (m_armed) begin
                if (out_valid) begin
                    check("q_vs_model", q, m_q);
                    check("div_zero_vs_model", div_zero, m_dz);
                end
            end else begin
                check("no_spurious_out_valid", out_valid, 1'b0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m_armed = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_div(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] tp,
                          input int hold, output logic [31:0] rq, output logic rdz,
                          output int lat);
        int guard;
        @(negedge clk);
        a = ta; b = tb_; poly = tp; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        m_q = (tb_ == 32'h0) ? 32'h0 : gf_div_model(ta, tb_, tp);
        m_dz = (tb_ == 32'h0);
        m_armed = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid) check("busy_in_run", {busy, in_ready}, 2'b10);
        end while (!out_valid && lat < GF_MAX_CYC + 20);
        check("latency_bound", (lat <= GF_MAX_CYC + 1), 1'b1);
        rq = q;
        rdz = div_zero;
        if (!out_valid) begin
            do_reset();
        end else begin
            for (int i = 0; i < hold; i++) begin
                in_valid = (i % 3 == 0);
                a = $urandom;
                b = $urandom;
                @(negedge clk);
                check("hold_out_valid", out_valid, 1'b1);
                check("hold_in_ready", in_ready, 1'b0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            m_armed = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rq, ra, rb;
        logic        rdz;
        int          lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'h0; b = 32'h0; poly = P1;
        repeat (3) @(negedge clk);
        check("reset_q", q, 32'h0);
        check("reset_div_zero", div_zero, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        live = 1'b1;

        // Pin the model itself with hand-derived values
        check("model_inv_x", gf_div_model(32'h1, 32'h2, P1), 32'h8020_0003);
        check("model_mul_x", gf_mul(32'h8020_0003, 32'h2, P1), 32'h1);

        do_div(32'h1, 32'h1, P1, 0, rq, rdz, lat);
        check("one_over_one_q", rq, 32'h1);
        check("one_over_one_dz", rdz, 1'b0);
        check("one_over_one_lat", lat, 2);

        do_div(32'h1, 32'h2, P1, 0, rq, rdz, lat);
        check("inv_x_q", rq, 32'h8020_0003);

        do_div(32'h2, 32'h2, P1, 0, rq, rdz, lat);
        check("x_over_x_q", rq, 32'h1);

        do_div(32'hDEAD_BEEF, 32'h0, P1, 0, rq, rdz, lat);
        check("div_zero_q", rq, 32'h0);
        check("div_zero_flag", rdz, 1'b1);
        check("div_zero_lat", lat, 1);

        // div_zero must clear on the next accept
        do_div(32'h0, 32'h1234_5679, P1, 0, rq, rdz, lat);
        check("zero_dividend_q", rq, 32'h0);
        check("div_zero_cleared", rdz, 1'b0);

        // Consumer stalls for 20 cycles with in_valid pulses in between
        do_div(32'hCAFE_F00D, 32'h0BAD_1DEA, P1, 20, rq, rdz, lat);
        check("stall_mul_back", gf_mul(rq, 32'h0BAD_1DEA, P1), 32'hCAFE_F00D);
        @(negedge clk);
        check("after_stall_in_ready", in_ready, 1'b1);
        check("after_stall_busy", busy, 1'b0);

        // Abort a division mid-run
        @(negedge clk);
        a = 32'h1357_9BDF; b = 32'hDEAD_BEEF; poly = P1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        m_q = gf_div_model(32'h1357_9BDF, 32'hDEAD_BEEF, P1);
        m_dz = 1'b0;
        m_armed = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_still_running", {busy, out_valid}, 2'b10);
        do_reset();
        @(negedge clk);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        do_div(32'h1, 32'h2, P1, 0, rq, rdz, lat);
        check("after_abort_q", rq, 32'h8020_0003);

        // Random operands in both fields
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pp;
            pp = (n < 250) ? P1 : P2;
            ra = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
            rb = $urandom;
            if (rb == 32'h0) rb = 32'h1;
            if ($urandom_range(0, 7) == 0) rb = 32'h1 << $urandom_range(0, 31);
            do_div(ra, rb, pp, $urandom_range(0, 2), rq, rdz, lat);
            check("rand_mul_back", gf_mul(rq, rb, pp), ra);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
